mfu_accumulator: RTL and testbench

//  Downstream stage of the 8x8 fused multiplier unit. It consumes the 16-bit

---
 rtl/mfu_accumulator_if.sv | 28 ++
 rtl/mfu_accumulator.sv | 104 ++++++++++
 tb/tb_mfu_accumulator.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mfu_accumulator_if.sv
// Handshake bundle between the accumulator, its control source and the MFU/consumer.
// master = the block driving start/len/products/out_ready, slave = the accumulator.
interface mfu_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output start, len, in_valid, in_prod, out_ready,
        input  busy, in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  start, len, in_valid, in_prod, out_ready,
        output busy, in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/mfu_accumulator.sv
// Sums a programmed run of unsigned MFU products into one dot-product result.
// Latency: result valid the cycle after the last product transfer; 1 product/cycle.
// Backpressure: in_ready only while accumulating; result held until out_ready.
// Build option MFU_ACC_SATURATE_EN clamps the sum on overflow instead of wrapping.
module mfu_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                nrst,
    mfu_accumulator_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  cnt;
    logic              ovf;

    logic [ACC_W:0]    sum_full;
    logic [ACC_W-1:0]  acc_next;
    logic              ovf_next;
    logic              xfer;
    logic              run_start;

    assign xfer      = bus.in_valid && (state == ACC);
    assign run_start = bus.start && (bus.len != '0);

    // One spare bit catches the carry out of the ACC_W-bit add.
    assign sum_full = {1'b0, acc} + (ACC_W+1)'(bus.in_prod);
    assign ovf_next = ovf | sum_full[ACC_W];

`ifdef MFU_ACC_SATURATE_EN
    assign acc_next = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign acc_next = sum_full[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_start) begin
                        acc          <= '0;
                        ovf          <= 1'b0;
                        cnt          <= bus.len;
                        state        <= ACC;
                        bus.in_ready <= 1'b1;
                        bus.busy     <= 1'b1;
                    end
                end
                ACC: begin
                    if (xfer) begin
                        acc <= acc_next;
                        ovf <= ovf_next;
                        cnt <= cnt - 1'b1;
                        // Last product: publish the sum in the same edge it is formed.
                        if (cnt == LEN_W'(1)) begin
                            bus.out_sum   <= acc_next;
                            bus.out_ovf   <= ovf_next;
                            bus.out_valid <= 1'b1;
                            bus.in_ready  <= 1'b0;
                            state         <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (run_start) begin
                            acc          <= '0;
                            ovf          <= 1'b0;
                            cnt          <= bus.len;
                            state        <= ACC;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfu_accumulator.sv
// Bench for mfu_accumulator: a 24-bit and a 16-bit instance share one stimulus
// stream; expected sums come from constants or a whole-run arithmetic model.
module tb_mfu_accumulator;

    logic clk;
    logic nrst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mfu_accumulator_if #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) ia();
    mfu_accumulator_if #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) ib();

    assign ib.start     = ia.start;
    assign ib.len       = ia.len;
    assign ib.in_valid  = ia.in_valid;
    assign ib.in_prod   = ia.in_prod;
    assign ib.out_ready = ia.out_ready;

    mfu_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) u_a (.clk(clk), .nrst(nrst), .bus(ia));
    mfu_accumulator #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) u_b (.clk(clk), .nrst(nrst), .bus(ib));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int     len;
        int     prods[4];
        int     stall;
        int     hold;
        longint exp_sum;
        bit     exp_ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Whole-run view: wrap == total mod 2^w, saturate == min(total, max).
    function automatic void model(input int w, input int p[$], output longint s, output bit o);
        longint maxv;
        longint tot;
        maxv = (longint'(1) << w) - 1;
        tot  = 0;
        foreach (p[k]) tot += p[k];
        o = (tot > maxv);
`ifdef MFU_ACC_SATURATE_EN
        s = o ? maxv : tot;
`else
        s = tot % (maxv + 1);
`endif
    endfunction

    task automatic begin_run(input int l);
        ia.start = 1'b1;
        ia.len   = 8'(l);
        @(negedge clk);
        ia.start = 1'b0;
        chk("busy_after_start", ia.busy, 1);
        chk("in_ready_after_start", ia.in_ready, 1);
    endtask

    task automatic feed(input int p[$], input int stall_pct);
        int i = 0;
        int guard = 0;
        while (i < p.size() && guard < 4000) begin
            chk("in_ready_in_acc", ia.in_ready, 1);
            chk("out_valid_in_acc", ia.out_valid, 0);
            chk("b_out_valid_in_acc", ib.out_valid, 0);
            ia.in_valid = ($urandom_range(99) >= stall_pct);
            ia.in_prod  = ia.in_valid ? 16'(p[i]) : 16'($urandom);
            ia.start    = 1'($urandom_range(1));
            ia.len      = 8'($urandom);
            @(negedge clk);
            if (ia.in_valid) i++;
            guard++;
        end
        if (guard >= 4000) chk("feed_budget", guard, 0);
        ia.in_valid = 1'b0;
        ia.start    = 1'b0;
        chk("latency_out_valid", ia.out_valid, 1);
        chk("b_latency_out_valid", ib.out_valid, 1);
        chk("in_ready_in_hold", ia.in_ready, 0);
    endtask

    task automatic check_result(input int p[$], input longint exp_a, input bit exp_oa, input int hold);
        longint sb;
        bit     ob;
        model(16, p, sb, ob);
        ia.out_ready = 1'b0;
        for (int k = 0; k <= hold; k++) begin
            chk("a_out_sum", ia.out_sum, exp_a);
            chk("a_out_ovf", ia.out_ovf, exp_oa);
            chk("b_out_sum", ib.out_sum, sb);
            chk("b_out_ovf", ib.out_ovf, ob);
            chk("hold_out_valid", ia.out_valid, 1);
            chk("hold_in_ready", ia.in_ready, 0);
            if (k < hold) @(negedge clk);
        end
    endtask

    task automatic release_hold(input bit chain, input int nl);
        bit exp_busy;
        exp_busy     = chain && (nl != 0);
        ia.out_ready = 1'b1;
        ia.start     = chain;
        ia.len       = 8'(nl);
        @(negedge clk);
        ia.out_ready = 1'b0;
        ia.start     = 1'b0;
        chk("release_busy", ia.busy, exp_busy);
        chk("release_in_ready", ia.in_ready, exp_busy);
        chk("release_out_valid", ia.out_valid, 0);
    endtask

    initial begin
        int     q[$];
        longint sa;
        bit     oa;
        int     l;
        int     nl_pend;
        bit     chain;
        int     nl;

        tbl[0] = '{4, '{65025, 65025, 65025, 65025}, 0, 0, 260100, 1'b0};
        tbl[1] = '{3, '{100, 200, 300, 0}, 40, 5, 600, 1'b0};
        tbl[2] = '{1, '{65535, 0, 0, 0}, 20, 1, 65535, 1'b0};
        tbl[3] = '{2, '{0, 0, 0, 0}, 0, 2, 0, 1'b0};
        tbl[4] = '{4, '{65535, 65535, 65535, 65535}, 30, 0, 262140, 1'b0};
        tbl[5] = '{2, '{65535, 2, 0, 0}, 0, 1, 65537, 1'b0};

        ia.start = 0; ia.len = 0; ia.in_valid = 0; ia.in_prod = 0; ia.out_ready = 0;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", ia.busy, 0);
        chk("rst_in_ready", ia.in_ready, 0);
        chk("rst_out_valid", ia.out_valid, 0);
        chk("rst_out_sum", ia.out_sum, 0);
        chk("rst_out_ovf", ia.out_ovf, 0);
        nrst = 1'b1;
        @(negedge clk);

        foreach (tbl[v]) begin
            q = {};
            for (int j = 0; j < tbl[v].len; j++) q.push_back(tbl[v].prods[j]);
            begin_run(tbl[v].len);
            feed(q, tbl[v].stall);
            check_result(q, tbl[v].exp_sum, tbl[v].exp_ovf, tbl[v].hold);
            if (v == 5) begin
`ifdef MFU_ACC_SATURATE_EN
                chk("ovf16_sat_sum", ib.out_sum, 65535);
`else
                chk("ovf16_wrap_sum", ib.out_sum, 1);
`endif
                chk("ovf16_flag", ib.out_ovf, 1);
            end
            release_hold(1'b0, 0);
        end

        // Reset three products into a five-product run.
        begin_run(5);
        for (int j = 0; j < 3; j++) begin
            ia.in_valid = 1'b1;
            ia.in_prod  = 16'(1000 * (j + 1));
            @(negedge clk);
        end
        ia.in_valid = 1'b0;
        nrst = 1'b0;
        #1;
        chk("midrst_busy", ia.busy, 0);
        chk("midrst_out_sum", ia.out_sum, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("postrst_busy", ia.busy, 0);
        chk("postrst_in_ready", ia.in_ready, 0);
        chk("postrst_out_valid", ia.out_valid, 0);
        chk("postrst_out_sum", ia.out_sum, 0);
        chk("postrst_out_ovf", ia.out_ovf, 0);

        // Zero-length start is ignored.
        ia.start = 1'b1;
        ia.len   = 8'd0;
        @(negedge clk);
        ia.start = 1'b0;
        chk("len0_busy", ia.busy, 0);
        chk("len0_in_ready", ia.in_ready, 0);
        @(negedge clk);
        chk("len0_busy_later", ia.busy, 0);

        // Back-to-back run straight out of HOLD.
        q = {1000, 2000, 3000};
        begin_run(3);
        feed(q, 0);
        check_result(q, 6000, 1'b0, 1);
        release_hold(1'b1, 2);
        q = {7, 8};
        feed(q, 10);
        check_result(q, 15, 1'b0, 0);
        release_hold(1'b1, 0);

        nl_pend = 0;
        for (int r = 0; r < 40; r++) begin
            if (nl_pend != 0) begin
                l = nl_pend;
            end else begin
                l = (r == 7) ? 255 : $urandom_range(1, 8);
                begin_run(l);
            end
            q = {};
            for (int j = 0; j < l; j++)
                q.push_back(($urandom_range(3) == 0) ? 65535 : $urandom_range(0, 65535));
            feed(q, 30);
            model(24, q, sa, oa);
            check_result(q, sa, oa, $urandom_range(0, 3));
            chain = 1'($urandom_range(1));
            nl    = chain ? $urandom_range(0, 6) : 0;
            release_hold(chain, nl);
            nl_pend = chain ? nl : 0;
        end
        if (nl_pend != 0) begin
            q = {};
            for (int j = 0; j < nl_pend; j++) q.push_back(j + 1);
            feed(q, 0);
            model(24, q, sa, oa);
            check_result(q, sa, oa, 0);
            release_hold(1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
